pid_output_stage: RTL and testbench
===================================

// Module: pid_output_stage
// PURPOSE
//  Downstream of the P, I and D term stages. Sums p/i/d contributions into a saturated signed control word u.
//  Converts u to offset-binary duty and drives a PWM actuator pin. Duty changes only at PWM period boundaries.
// PARAMETERS
//  IN_W   8  width of each signed contribution (p/i/d_contrib)
//  OUT_W  8  width of signed control word u; also PWM counter/duty width (period = 2^OUT_W clk)
// PORTS
//  clk            in   1      system clock, all logic on rising edge
//  rst            in   1      synchronous, active-high reset
//  ena            in   1      global enable; low = hold all state, pwm_out forced 0
//  p_contrib      in   IN_W   signed proportional term
//  i_contrib      in   IN_W   signed integral term
//  d_contrib      in   IN_W   signed derivative term
//  sample_valid   in   1      1-cycle strobe: contributions valid this cycle
//  u              out  OUT_W  signed saturated control word (registered)
//  u_valid        out  1      1-cycle strobe: u updated this cycle
//  sat            out  1      last u was clamped (sticky until next u_valid)
//  duty           out  OUT_W  duty currently applied to PWM (unsigned)
//  period_start   out  1      1-cycle strobe when PWM counter is 0 (new duty latched)
//  pwm_out        out  1      actuator PWM output (registered)
// BEHAVIOUR
//  Reset (rst=1 at edge): u=0, u_valid=0, sat=0, duty=0, duty_pending=2^(OUT_W-1), cnt=0, period_start=0, pwm_out=0.
//  Stage 1, cycle N (sample_valid & ena): sum = sext(p)+sext(i)+sext(d) in IN_W+2 bits, registered; s1_vld=1.
//  Stage 2, cycle N+1: clamp sum to [-2^(OUT_W-1), 2^(OUT_W-1)-1] -> u; sat=1 iff clamped.
//   - u_valid pulses at N+2 (latency 2). duty_pending = u + 2^(OUT_W-1) (flip MSB).
//  Back-to-back sample_valid every cycle allowed; fully pipelined, no backpressure.
//  PWM: cnt increments each enabled cycle, wraps 2^OUT_W-1 -> 0.
//   - When cnt==0: duty <= duty_pending, period_start=1.
//   - pwm_out = (cnt < duty) registered; one-cycle delay vs cnt accepted.
//   - duty=0 -> pwm_out always 0; duty=2^OUT_W-1 -> high 2^OUT_W-1 of 2^OUT_W cycles.
//  Multiple u updates within a period: last duty_pending before cnt==0 wins.
//  u_valid coincident with cnt==0: duty takes the OLD duty_pending; new value applies next period.
//  ena=0: pipeline regs, cnt, duty hold; strobes 0; pwm_out=0; sample_valid ignored.
//   - On ena re-assert, counting resumes from held cnt.
//  rst mid-period or mid-pipeline: all state to reset values next cycle; in-flight samples dropped.
//  Until first period boundary after reset, pwm_out=0 (duty=0). Thereafter mid-scale until first u.
//  Arithmetic: two's complement throughout; IN_W+2 bits cannot overflow for 3 operands.
//   - Requires OUT_W <= IN_W+2.
// STRUCTURE
//  pid_pkg: IN_W/OUT_W defaults, SUM_W = IN_W+2, U_MAX/U_MIN constants, to_offset_binary helper function.
//  Sub-module pwm_gen (cnt, duty double-buffer, period_start, pwm_out); top holds adder + saturator pipeline.
// TESTING
//  1 p=10,i=20,d=-5, one strobe -> u=25 at +2 cycles, u_valid pulse, sat=0. Next period_start -> duty=153.
//  2 p=i=d=100 (sum 300) -> u=127, sat=1, duty=255; p=i=d=-100 -> u=-128, sat=1, duty=0, pwm_out constant 0.
//  3 strobes u=0 then u=64 in same period -> only duty=192 applied at next cnt==0; pwm high 192 of 256 cycles.
//  4 u_valid lands on cnt==0 -> duty unchanged that period, updated at following period_start.
//  5 ena low 50 cycles mid-period -> pwm_out=0, cnt/duty frozen; ena high resumes same cnt, same duty.
//  6 rst pulse mid-period with duty=200 -> next cycle all outputs at reset values; pwm_out 0 for first period.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared constants and helpers for the PID output stage.
package pid_pkg;

    // Default contribution and control-word widths.
    localparam int DEF_IN_W  = 8;
    localparam int DEF_OUT_W = 8;

    // Three sign-extended addends need two extra bits to be overflow-free.
    localparam int SUM_W = DEF_IN_W + 2;

    // Saturation limits of u at the default width.
    localparam int U_MAX = (1 << (DEF_OUT_W - 1)) - 1;
    localparam int U_MIN = -(1 << (DEF_OUT_W - 1));

    // Signed value of width w to offset binary (adds half scale, i.e. flips the MSB).
    function automatic int to_offset_binary(input int v, input int w);
        return v + (1 << (w - 1));
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// PWM generator: free-running counter, double-buffered duty that only changes
// when the counter wraps, period_start strobe and registered PWM output.
module pwm_gen #(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
    input  logic [OUT_W-1:0] load_value,
    output logic [OUT_W-1:0] duty,
    output logic             period_start,
    output logic             pwm_out
);

    localparam logic [OUT_W-1:0] CNT_MAX  = '1;
    localparam logic [OUT_W-1:0] MID_DUTY = {1'b1, {(OUT_W-1){1'b0}}};

    logic [OUT_W-1:0] cnt_reg;
    logic [OUT_W-1:0] duty_reg;
    logic [OUT_W-1:0] duty_pending_reg;
    logic             period_start_reg;
    logic             pwm_out_reg;
    logic             wrap;

    // The edge that takes the counter from max back to 0 is the period boundary.
    assign wrap = (cnt_reg == CNT_MAX);

    // Counter and duty double buffer; a load on the wrap edge lands in the
    // pending slot only, so the new period still takes the previous value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg          <= '0;
            duty_reg         <= '0;
            duty_pending_reg <= MID_DUTY;
        end else if (ena) begin
            cnt_reg <= cnt_reg + OUT_W'(1);
            if (wrap) begin
                duty_reg <= duty_pending_reg;
            end
            if (load) begin
                duty_pending_reg <= load_value;
            end
        end
    end

    // Registered outputs; both forced low while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_start_reg <= 1'b0;
            pwm_out_reg      <= 1'b0;
        end else if (ena) begin
            period_start_reg <= wrap;
            pwm_out_reg      <= (cnt_reg < duty_reg);
        end else begin
            period_start_reg <= 1'b0;
            pwm_out_reg      <= 1'b0;
        end
    end

    assign duty         = duty_reg;
    assign period_start = period_start_reg;
    assign pwm_out      = pwm_out_reg;

endmodule

// File: rtl/pid_output_stage.sv
// PID output stage: sums P/I/D contributions, saturates to a signed control
// word u (two-cycle pipeline) and drives a PWM actuator from u.
// OUT_W must not exceed IN_W + 2.
module pid_output_stage
    import pid_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic signed [IN_W-1:0]  p_contrib,
    input  logic signed [IN_W-1:0]  i_contrib,
    input  logic signed [IN_W-1:0]  d_contrib,
    input  logic                    sample_valid,
    output logic signed [OUT_W-1:0] u,
    output logic                    u_valid,
    output logic                    sat,
    output logic [OUT_W-1:0]        duty,
    output logic                    period_start,
    output logic                    pwm_out
);

    localparam int S_W = IN_W + 2;
    localparam logic signed [S_W-1:0] SUM_HI = S_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [S_W-1:0] SUM_LO = S_W'(-(1 << (OUT_W - 1)));

    logic signed [S_W-1:0]   sum_next;
    logic signed [S_W-1:0]   sum_reg;
    logic                    s1_vld_reg;
    logic signed [OUT_W-1:0] u_next;
    logic                    clamped;
    logic signed [OUT_W-1:0] u_reg;
    logic                    u_valid_reg;
    logic                    sat_reg;
    logic [OUT_W-1:0]        pend_value;

    assign sum_next = {{2{p_contrib[IN_W-1]}}, p_contrib}
                    + {{2{i_contrib[IN_W-1]}}, i_contrib}
                    + {{2{d_contrib[IN_W-1]}}, d_contrib};

    // Stage 1: register the wide sum; everything holds while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg    <= '0;
            s1_vld_reg <= 1'b0;
        end else if (ena) begin
            s1_vld_reg <= sample_valid;
            if (sample_valid) begin
                sum_reg <= sum_next;
            end
        end
    end

    // Saturate the registered sum into the OUT_W signed range.
    always_comb begin
        u_next  = sum_reg[OUT_W-1:0];
        clamped = 1'b0;
        if (sum_reg > SUM_HI) begin
            u_next  = SUM_HI[OUT_W-1:0];
            clamped = 1'b1;
        end else if (sum_reg < SUM_LO) begin
            u_next  = SUM_LO[OUT_W-1:0];
            clamped = 1'b1;
        end
    end

    // Stage 2: register u and the sticky sat flag; u_valid is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            u_reg       <= '0;
            u_valid_reg <= 1'b0;
            sat_reg     <= 1'b0;
        end else if (ena) begin
            u_valid_reg <= s1_vld_reg;
            if (s1_vld_reg) begin
                u_reg   <= u_next;
                sat_reg <= clamped;
            end
        end else begin
            u_valid_reg <= 1'b0;
        end
    end

    // The pending duty is loaded on the same edge that updates u.
    assign pend_value = OUT_W'(to_offset_binary(int'(u_next), OUT_W));

    pwm_gen #(
        .OUT_W(OUT_W)
    ) u_pwm_gen (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .load        (s1_vld_reg),
        .load_value  (pend_value),
        .duty        (duty),
        .period_start(period_start),
        .pwm_out     (pwm_out)
    );

    assign u       = u_reg;
    assign u_valid = u_valid_reg;
    assign sat     = sat_reg;

endmodule

// File: tb/tb_pid_output_stage.sv
// Self-checking bench for pid_output_stage: directed scenarios plus a
// randomized back-to-back burst checked against an arithmetic reference.
module tb_pid_output_stage;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ena = 1'b1;
    logic signed [7:0] p_contrib = '0;
    logic signed [7:0] i_contrib = '0;
    logic signed [7:0] d_contrib = '0;
    logic              sample_valid = 1'b0;
    logic signed [7:0] u;
    logic              u_valid;
    logic              sat;
    logic [7:0]        duty;
    logic              period_start;
    logic              pwm_out;

    int tests_run    = 0;
    int tests_failed = 0;

    pid_output_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .p_contrib   (p_contrib),
        .i_contrib   (i_contrib),
        .d_contrib   (d_contrib),
        .sample_valid(sample_valid),
        .u           (u),
        .u_valid     (u_valid),
        .sat         (sat),
        .duty        (duty),
        .period_start(period_start),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the contributions.
    function automatic int ref_u(input int a, input int b, input int c);
        int s;
        s = a + b + c;
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    function automatic bit ref_sat(input int a, input int b, input int c);
        int s;
        s = a + b + c;
        return (s > 127) || (s < -128);
    endfunction

    function automatic int ref_duty(input int uu);
        return uu + 128;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int a, input int b, input int c);
        p_contrib    = 8'(a);
        i_contrib    = 8'(b);
        d_contrib    = 8'(c);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        $display("[TB] sample p=%0d i=%0d d=%0d", a, b, c);
    endtask

    // Advance until period_start is seen; bounded.
    task automatic wait_ps(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 600);
        tests_run++;
        if (!period_start) begin
            tests_failed++;
            $display("FAIL wait_period_start: no strobe after %0d cycles, required within 600", n);
        end
    endtask

    // Count pwm_out high cycles over one full period.
    task automatic count_high(output int n);
        n = 0;
        repeat (256) begin
            tick();
            n += int'(pwm_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ena = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({u, u_valid, sat, duty, period_start, pwm_out} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_state: u=%0d uv=%0b sat=%0b duty=%0d ps=%0b pwm=%0b, required all 0",
                     u, u_valid, sat, duty, period_start, pwm_out);
        end
        rst = 1'b0;
        $display("[TB] reset done");
    endtask

    task automatic test_single();
        logic signed [7:0] eu;
        int n;
        eu = 8'(ref_u(10, 20, -5));
        strobe(10, 20, -5);
        tests_run++;
        if (u_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_latency1: u_valid=%0b, required 0", u_valid);
        end
        tick();
        tests_run++;
        if (u_valid !== 1'b1 || u !== eu || sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_u: uv=%0b u=%0d sat=%0b, required uv=1 u=%0d sat=0", u_valid, u, sat, eu);
        end
        tick();
        tests_run++;
        if (u_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_strobe_len: u_valid=%0b, required 0", u_valid);
        end
        wait_ps(n);
        tests_run++;
        if (duty !== 8'(ref_duty(int'(eu)))) begin
            tests_failed++;
            $display("FAIL single_duty: duty=%0d, required %0d", duty, ref_duty(int'(eu)));
        end
        $display("[TB] single u=%0d duty=%0d", u, duty);
    endtask

    task automatic test_saturation();
        int n;
        strobe(100, 100, 100);
        tick();
        tests_run++;
        if (u !== 8'(ref_u(100, 100, 100)) || sat !== ref_sat(100, 100, 100)) begin
            tests_failed++;
            $display("FAIL sat_high: u=%0d sat=%0b, required %0d 1", u, sat, ref_u(100, 100, 100));
        end
        repeat (5) tick();
        tests_run++;
        if (sat !== 1'b1 || u_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_sticky: sat=%0b uv=%0b, required sat=1 uv=0", sat, u_valid);
        end
        wait_ps(n);
        tests_run++;
        if (duty !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_high_duty: duty=%0d, required 255", duty);
        end
        count_high(n);
        tests_run++;
        if (n != 255) begin
            tests_failed++;
            $display("FAIL pwm_high_count_255: high=%0d, required 255", n);
        end
        strobe(-100, -100, -100);
        tick();
        tests_run++;
        if (u !== 8'(ref_u(-100, -100, -100)) || sat !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_low: u=%0d sat=%0b, required %0d 1", u, sat, ref_u(-100, -100, -100));
        end
        wait_ps(n);
        tests_run++;
        if (duty !== 8'd0) begin
            tests_failed++;
            $display("FAIL sat_low_duty: duty=%0d, required 0", duty);
        end
        count_high(n);
        tests_run++;
        if (n != 0) begin
            tests_failed++;
            $display("FAIL pwm_high_count_0: high=%0d, required 0", n);
        end
        $display("[TB] saturation checked");
    endtask

    task automatic test_last_wins();
        int n;
        strobe(0, 0, 0);
        repeat (5) tick();
        strobe(64, 0, 0);
        tick();
        tests_run++;
        if (u !== 8'sd64) begin
            tests_failed++;
            $display("FAIL last_wins_u: u=%0d, required 64", u);
        end
        wait_ps(n);
        tests_run++;
        if (duty !== 8'(ref_duty(64))) begin
            tests_failed++;
            $display("FAIL last_wins_duty: duty=%0d, required %0d", duty, ref_duty(64));
        end
        count_high(n);
        tests_run++;
        if (n != 192) begin
            tests_failed++;
            $display("FAIL pwm_high_count_192: high=%0d, required 192", n);
        end
        $display("[TB] last-wins duty=%0d high=%0d", duty, n);
    endtask

    task automatic test_boundary();
        int n;
        wait_ps(n);
        repeat (254) tick();
        strobe(-64, 0, 0);
        tick();
        tests_run++;
        if (period_start !== 1'b1 || u_valid !== 1'b1 || duty !== 8'd192) begin
            tests_failed++;
            $display("FAIL boundary_old_duty: ps=%0b uv=%0b duty=%0d, required ps=1 uv=1 duty=192",
                     period_start, u_valid, duty);
        end
        wait_ps(n);
        tests_run++;
        if (n != 256 || duty !== 8'(ref_duty(-64))) begin
            tests_failed++;
            $display("FAIL boundary_new_duty: cycles=%0d duty=%0d, required 256 %0d", n, duty, ref_duty(-64));
        end
        $display("[TB] boundary duty=%0d", duty);
    endtask

    task automatic test_enable_hold();
        int n;
        int bad;
        repeat (100) tick();
        ena = 1'b0;
        p_contrib = 8'sd50;
        sample_valid = 1'b1;
        bad = 0;
        repeat (50) begin
            tick();
            if (pwm_out !== 1'b0 || u_valid !== 1'b0 || period_start !== 1'b0 || duty !== 8'd64) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL ena_low_hold: %0d bad cycles, required 0", bad);
        end
        sample_valid = 1'b0;
        ena = 1'b1;
        wait_ps(n);
        tests_run++;
        if (n != 156 || duty !== 8'd64 || u !== -8'sd64) begin
            tests_failed++;
            $display("FAIL ena_resume: cycles=%0d duty=%0d u=%0d, required 156 64 -64", n, duty, u);
        end
        $display("[TB] enable hold resume after %0d cycles", n);
    endtask

    task automatic test_back_to_back();
        int exp_q[$];
        bit sat_q[$];
        int a, b, c, last, got, n;
        got = 0;
        last = 0;
        for (int k = 0; k < 40; k++) begin
            sample_valid = 1'b0;
            if (k < 32 && $urandom_range(0, 3) != 0) begin
                a = $urandom_range(0, 255) - 128;
                b = $urandom_range(0, 255) - 128;
                c = $urandom_range(0, 255) - 128;
                p_contrib = 8'(a);
                i_contrib = 8'(b);
                d_contrib = 8'(c);
                sample_valid = 1'b1;
                exp_q.push_back(ref_u(a, b, c));
                sat_q.push_back(ref_sat(a, b, c));
                last = ref_u(a, b, c);
            end
            tick();
            if (u_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_spurious: u_valid=1 u=%0d, required no strobe", u);
                end else begin
                    a = exp_q.pop_front();
                    b = int'(sat_q.pop_front());
                    got++;
                    $display("[TB] b2b u=%0d sat=%0b exp=%0d/%0d", u, sat, a, b);
                    if (u !== 8'(a) || sat !== b[0]) begin
                        tests_failed++;
                        $display("FAIL b2b_u: u=%0d sat=%0b, required %0d %0d", u, sat, a, b);
                    end
                end
            end
        end
        sample_valid = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_drain: %0d results missing, required 0", exp_q.size());
        end
        if (got > 0) begin
            wait_ps(n);
            tests_run++;
            if (duty !== 8'(ref_duty(last))) begin
                tests_failed++;
                $display("FAIL b2b_duty: duty=%0d, required %0d", duty, ref_duty(last));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, highs, uvs;
        strobe(72, 0, 0);
        wait_ps(n);
        tests_run++;
        if (duty !== 8'd200) begin
            tests_failed++;
            $display("FAIL rst_mid_setup: duty=%0d, required 200", duty);
        end
        repeat (50) tick();
        strobe(50, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({u, u_valid, sat, duty, period_start, pwm_out} !== 20'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_state: u=%0d uv=%0b sat=%0b duty=%0d ps=%0b pwm=%0b, required all 0",
                     u, u_valid, sat, duty, period_start, pwm_out);
        end
        highs = 0;
        uvs = 0;
        repeat (256) begin
            tick();
            highs += int'(pwm_out);
            uvs += int'(u_valid);
        end
        tests_run++;
        if (highs != 0 || uvs != 0) begin
            tests_failed++;
            $display("FAIL rst_mid_first_period: high=%0d u_valid=%0d, required 0 0", highs, uvs);
        end
        tests_run++;
        if (period_start !== 1'b1 || duty !== 8'd128) begin
            tests_failed++;
            $display("FAIL rst_mid_midscale: ps=%0b duty=%0d, required 1 128", period_start, duty);
        end
        $display("[TB] reset mid-period, then duty=%0d", duty);
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_last_wins();
        test_boundary();
        test_enable_hold();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
